// File: rtl/dt_mem_responder.sv
// dt_mem_responder
// Memory-side responder for the distance-transform engine. Holds the binary
// source image (sti, 16 pixels per word, MSB = leftmost column) and the
// 8-bit distance result image (res). It runs the whole job:
//   IDLE -> LOAD  (host streams sti words from address 0)
//        -> CLEAR (res zeroed, one pixel per cycle)
//        -> RUN   (engine out of reset, its sti/res accesses are served)
//        -> DUMP  (res streamed back to the host with valid/ready)
//        -> IDLE
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   i_start           one-cycle pulse, starts LOAD from IDLE
//   i_load_valid      host sti word valid
//   o_load_ready      responder accepts sti word (LOAD only)
//   i_load_data       sti word, delivered in address order
//   o_dump_valid      res pixel available (DUMP only)
//   i_dump_ready      host accepts res pixel
//   o_dump_data       res[dump pointer]
//   o_dump_last       high with the final pixel
//   o_busy            any state other than IDLE
//   o_dt_rst_n        engine reset, active-low, released only in RUN
//   i_done            engine finished
//   i_sti_rd          engine sti read strobe (reads are combinational)
//   i_sti_addr        engine sti word address
//   o_sti_di          sti[i_sti_addr]
//   i_res_rd          engine res read strobe (reads are combinational)
//   i_res_wr          engine res write strobe (honoured in RUN only)
//   i_res_addr        engine res address
//   i_res_do          engine res write data
//   o_res_di          res[i_res_addr]

module dt_mem_responder #(
    parameter int STI_AW = 10,
    parameter int STI_DW = 16,
    parameter int RES_AW = 14,
    parameter int RES_DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [STI_DW-1:0] i_load_data,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [RES_DW-1:0] o_dump_data,
    output logic              o_dump_last,
    output logic              o_busy,
    output logic              o_dt_rst_n,
    input  logic              i_done,
    input  logic              i_sti_rd,
    input  logic [STI_AW-1:0] i_sti_addr,
    output logic [STI_DW-1:0] o_sti_di,
    input  logic              i_res_rd,
    input  logic              i_res_wr,
    input  logic [RES_AW-1:0] i_res_addr,
    input  logic [RES_DW-1:0] i_res_do,
    output logic [RES_DW-1:0] o_res_di
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DUMP
    } state_t;

    localparam logic [STI_AW-1:0] STI_LAST = '1;
    localparam logic [RES_AW-1:0] RES_LAST = '1;

    state_t            r_state;
    state_t            w_nextState;
    logic [STI_AW-1:0] r_ldPtr;
    logic [RES_AW-1:0] r_clrPtr;
    logic [RES_AW-1:0] r_dumpPtr;
    logic              r_dtRstN;

    logic [STI_DW-1:0] r_sti [0:(2**STI_AW)-1];
    logic [RES_DW-1:0] r_res [0:(2**RES_AW)-1];

    logic              w_loadFire;
    logic              w_dumpFire;
    logic              w_unusedStrobes;

    // Reads are purely combinational, so the engine's read strobes carry no
    // information; they are folded here only so they count as consumed.
    assign w_unusedStrobes = i_sti_rd ^ i_res_rd;

    assign w_loadFire = (r_state == S_LOAD) && i_load_valid;
    assign w_dumpFire = (r_state == S_DUMP) && i_dump_ready;

    assign o_sti_di    = r_sti[i_sti_addr];
    assign o_res_di    = r_res[i_res_addr];
    assign o_dump_data = r_res[r_dumpPtr];
    assign o_dt_rst_n  = r_dtRstN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Each phase ends on the cycle its pointer sits on the last address; the
    // pointer then wraps to 0 on its own, so no extra terminal bit is kept.
    always_comb begin
        w_nextState  = r_state;
        o_load_ready = 1'b0;
        o_dump_valid = 1'b0;
        o_dump_last  = 1'b0;
        o_busy       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                o_load_ready = 1'b1;
                if (i_load_valid && (r_ldPtr == STI_LAST)) begin
                    w_nextState = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_clrPtr == RES_LAST) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (i_done) begin
                    w_nextState = S_DUMP;
                end
            end
            S_DUMP: begin
                o_dump_valid = 1'b1;
                o_dump_last  = (r_dumpPtr == RES_LAST);
                if (i_dump_ready && (r_dumpPtr == RES_LAST)) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ldPtr   <= '0;
            r_clrPtr  <= '0;
            r_dumpPtr <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_ldPtr <= '0;
            end else if (w_loadFire) begin
                r_ldPtr <= r_ldPtr + STI_AW'(1);
            end

            if (w_loadFire && (r_ldPtr == STI_LAST)) begin
                r_clrPtr <= '0;
            end else if (r_state == S_CLEAR) begin
                r_clrPtr <= r_clrPtr + RES_AW'(1);
            end

            if ((r_state == S_RUN) && i_done) begin
                r_dumpPtr <= '0;
            end else if (w_dumpFire) begin
                r_dumpPtr <= r_dumpPtr + RES_AW'(1);
            end
        end
    end

    // Registered so the engine leaves reset one cycle after RUN is entered,
    // and is put back into reset on the same edge that samples done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dtRstN <= 1'b0;
        end else begin
            r_dtRstN <= (r_state == S_RUN) && (w_nextState == S_RUN);
        end
    end

    // Memory arrays have no reset: contents deliberately survive it.
    always_ff @(posedge clk) begin
        if (w_loadFire) begin
            r_sti[r_ldPtr] <= i_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_res[r_clrPtr] <= '0;
        end else if ((r_state == S_RUN) && i_res_wr) begin
            r_res[i_res_addr] <= i_res_do;
        end
    end

endmodule
